// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply, restoring divide, sign fix-up in a final cycle.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op_EX,
    input  logic [31:0] EX_MX1,
    input  logic [31:0] EX_MX2,
    input  logic        hilo_read_EX,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opb_q;
    logic [32:0] rem_q;
    logic [31:0] hi_q, lo_q;
    logic        div_q, neg_q, nega_q, dz_q, done_q;

    logic        is_muldiv, is_div, op_signed, start;
    logic        a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift, div_trial, rem_next;
    logic        div_ge;
    logic [31:0] quot_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix, hi_res, lo_res;

    assign is_muldiv = (op_EX == OP_MULT) | (op_EX == OP_MULTU)
                     | (op_EX == OP_DIV)  | (op_EX == OP_DIVU);
    assign is_div    = (op_EX == OP_DIV) | (op_EX == OP_DIVU);
    assign op_signed = (op_EX == OP_MULT) | (op_EX == OP_DIV);
    assign start     = (state_q == S_IDLE) & is_muldiv;

    assign a_neg = op_signed & EX_MX1[31];
    assign b_neg = op_signed & EX_MX2[31];
    assign a_abs = a_neg ? -EX_MX1 : EX_MX1;
    assign b_abs = b_neg ? -EX_MX2 : EX_MX2;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc[31:0] shifts dividend out and quotient in
    assign div_shift = {rem_q[31:0], acc_q[31]};
    assign div_trial = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_trial[32];
    assign rem_next  = div_ge ? div_trial : div_shift;
    assign quot_next = {acc_q[30:0], div_ge};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quot_fix = dz_q ? 32'hFFFF_FFFF
                    : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
    assign rem_fix  = nega_q ? -rem_q[31:0] : rem_q[31:0];
    assign hi_res   = div_q ? rem_fix  : prod_fix[63:32];
    assign lo_res   = div_q ? quot_fix : prod_fix[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_ITER;
            S_ITER:  if (cnt_q == 6'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        stall = busy & (((op_EX != OP_NONE) & (op_EX != OP_RSVD)) | hilo_read_EX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opb_q  <= '0;
            rem_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            nega_q <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_FIX);
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q  <= {32'd0, is_div ? a_abs : b_abs};
                        opb_q  <= is_div ? b_abs : a_abs;
                        rem_q  <= '0;
                        div_q  <= is_div;
                        neg_q  <= a_neg ^ b_neg;
                        nega_q <= a_neg;
                        dz_q   <= is_div & (EX_MX2 == 32'd0);
                        cnt_q  <= '0;
                    end else if (op_EX == OP_MTHI) begin
                        hi_q <= EX_MX1;
                    end else if (op_EX == OP_MTLO) begin
                        lo_q <= EX_MX1;
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (div_q) begin
                        acc_q[31:0] <= quot_next;
                        rem_q       <= rem_next;
                    end else begin
                        acc_q <= mul_next;
                    end
                end
                S_FIX: begin
                    hi_q <= hi_res;
                    lo_q <= lo_res;
                end
                default: ;
            endcase
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign done   = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit.
// Directed corner cases plus random ops against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op_EX;
    logic [31:0] EX_MX1, EX_MX2;
    logic        hilo_read_EX;
    logic [31:0] hi_out, lo_out;
    logic        busy, done, stall;

    int n_checks = 0;
    int n_fail   = 0;

    hilo_muldiv_unit dut (
        .clk          (clk),
        .reset        (reset),
        .op_EX        (op_EX),
        .EX_MX1       (EX_MX1),
        .EX_MX2       (EX_MX2),
        .hilo_read_EX (hilo_read_EX),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .busy         (busy),
        .done         (done),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    // Architectural HI/LO effect of one op, from plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b,
                                  inout logic [31:0] h, inout logic [31:0] l);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        case (op)
            3'd1: begin
                sa = 64'(signed'(a));
                sb = 64'(signed'(b));
                p  = sa * sb;
                h  = p[63:32];
                l  = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            3'd3: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    sa = 64'(signed'(a));
                    sb = 64'(signed'(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    l  = q[31:0];
                    h  = r[31:0];
                end
            end
            3'd4: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
            3'd5: h = a;
            3'd6: l = a;
            default: ;
        endcase
    endfunction

    // Issue one op; for mul/div wait (bounded) for done and report cycles.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        op_EX  = op;
        EX_MX1 = a;
        EX_MX2 = b;
        @(posedge clk);
        #1;
        op_EX = 3'd0;
        lat   = 0;
        if (op >= 3'd1 && op <= 3'd4) begin
            while (done !== 1'b1 && lat < 60) begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (hi_out !== 32'd0) begin
            n_fail++; $display("FAIL reset_hi: got %h want 0", hi_out);
        end
        n_checks++;
        if (lo_out !== 32'd0) begin
            n_fail++; $display("FAIL reset_lo: got %h want 0", lo_out);
        end
        n_checks++;
        if ({busy, done, stall} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: busy/done/stall=%b want 000", {busy, done, stall});
        end
    endtask

    task automatic test_multu_max;
        int lat;
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        n_checks++;
        if (lat != 33) begin
            n_fail++; $display("FAIL multu_latency: got %0d want 33", lat);
        end
        n_checks++;
        if (hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001) begin
            n_fail++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi_out, lo_out);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_at_done: got %b want 0", busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL done_width: got %b want 0", done);
        end
    endtask

    task automatic test_directed;
        logic [2:0]  ops [6] = '{3'd1, 3'd4, 3'd3, 3'd3, 3'd4, 3'd3};
        logic [31:0] as  [6] = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'h0000_1234, 32'hFFFF_FFF9};
        logic [31:0] bs  [6] = '{32'd7, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
                                 32'd0, 32'h0000_1234, 32'hFFFF_FFF9};
        logic [31:0] el  [6] = '{32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD,
                                 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], lat);
            n_checks++;
            if (lat != 33 || hi_out !== eh[i] || lo_out !== el[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got lat %0d %h_%h want 33 %h_%h",
                         i, lat, hi_out, lo_out, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_stall;
        int lat;
        int bad;
        op_EX  = 3'd1;
        EX_MX1 = 32'd5;
        EX_MX2 = 32'd6;
        @(posedge clk);
        #1;
        op_EX        = 3'd1;
        EX_MX1       = 32'd9;
        EX_MX2       = 32'd9;
        hilo_read_EX = 1'b1;
        lat = 0;
        bad = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1 || stall !== 1'b1) bad++;
            @(posedge clk);
            #1;
            lat++;
        end
        op_EX = 3'd0;
        n_checks++;
        if (bad != 0 || lat != 33) begin
            n_fail++; $display("FAIL stall_busy: bad cycles %0d lat %0d want 0 33", bad, lat);
        end
        n_checks++;
        if (hi_out !== 32'd0 || lo_out !== 32'd30) begin
            n_fail++; $display("FAIL stall_result: got %h_%h want 0_1e", hi_out, lo_out);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle: got %b want 0", stall);
        end
        hilo_read_EX = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL ignored_op: busy %b want 0", busy);
        end
    endtask

    task automatic test_mthi_mtlo;
        int lat;
        do_op(3'd5, 32'h1357_9BDF, 32'd0, lat);
        do_op(3'd6, 32'hA5A5_A5A5, 32'd0, lat);
        n_checks++;
        if (hi_out !== 32'h1357_9BDF || lo_out !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL mtlo: got %h_%h want 13579bdf_a5a5a5a5", hi_out, lo_out);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mt_flags: busy %b done %b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        op_EX  = 3'd3;
        EX_MX1 = 32'd1000;
        EX_MX2 = 32'd3;
        @(posedge clk);
        #1;
        op_EX = 3'd0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({hi_out, lo_out} !== 64'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h_%h busy %b done %b want all 0",
                     hi_out, lo_out, busy, done);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL reset_no_done: got %0d pulses want 0", seen);
        end
        do_op(3'd1, 32'd2, 32'd3, lat);
        n_checks++;
        if (lat != 33 || hi_out !== 32'd0 || lo_out !== 32'd6) begin
            n_fail++; $display("FAIL after_reset_mult: got lat %0d %h_%h want 33 0_6", lat, hi_out, lo_out);
        end
    endtask

    // Chained random ops: each mul/div starts the cycle right after done.
    task automatic test_back_to_back;
        logic [31:0] corners [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF,
                                     32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        logic [31:0] hm, lm, a, b;
        logic [2:0]  op;
        int lat;
        hm = 32'd0;
        lm = 32'd6;
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            model(op, a, b, hm, lm);
            do_op(op, a, b, lat);
            n_checks++;
            if (hi_out !== hm || lo_out !== lm) begin
                n_fail++;
                $display("FAIL random_%0d op %0d a %h b %h: got %h_%h want %h_%h",
                         i, op, a, b, hi_out, lo_out, hm, lm);
            end
            if (op >= 3'd1 && op <= 3'd4) begin
                n_checks++;
                if (lat != 33) begin
                    n_fail++; $display("FAIL random_lat_%0d: got %0d want 33", i, lat);
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        op_EX        = 3'd0;
        EX_MX1       = 32'd0;
        EX_MX2       = 32'd0;
        hilo_read_EX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        reset = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_multu_max;
        test_directed;
        test_stall;
        test_mthi_mtlo;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the decoded HI/LO operation and the two source operands (EX_MX1, EX_MX2) from ID/EX. It owns the architectural HI and LO registers and drives them back as the hi/lo signals. While an operation is in flight it raises a stall request so upstream pipeline registers hold.

## Interface
Parameters:
- none; data width is fixed at 32 bits and the iteration count at 32.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- op_EX  input  3  operation code: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 treated as none
- EX_MX1  input  32  operand A (rs value; dividend / multiplicand / MTHI-MTLO source)
- EX_MX2  input  32  operand B (rt value; divisor / multiplier)
- hilo_read_EX  input  1  instruction in EX reads HI or LO (MFHI/MFLO)
- hi_out  output  32  architectural HI register
- lo_out  output  32  architectural LO register
- busy  output  1  mul/div in progress
- done  output  1  one-cycle pulse: HI/LO just updated by mul/div
- stall  output  1  hold request to PC, IF/ID and ID/EX

## Operation
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- State machine has three states: IDLE, ITER and FIX.
- IDLE, op_EX in {MULT, MULTU, DIV, DIVU}:
  - Latch the operands. Signed ops latch absolute values and record the result signs. Unsigned ops latch raw values.
  - Clear the 6-bit iteration counter, go to ITER.
- IDLE, op_EX = MTHI/MTLO:
  - Write EX_MX1 into HI or LO at the next edge.
  - No busy, no done; the other register is unchanged.
- ITER, multiply:
  - Shift-add radix-2 on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- ITER, divide:
  - Restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder, 32-bit quotient.
- ITER exit: counter increments each cycle; after the 32nd iteration (counter = 31) go to FIX.
- FIX, sign correction:
  - MULT: negate the 64-bit product if sign(A) XOR sign(B).
  - DIV: negate the quotient if sign(A) XOR sign(B); the remainder takes the sign of A.
- FIX, writeback and exit: write HI = product[63:32] or remainder, and LO = product[31:0] or quotient. Pulse done, return to IDLE.
- Divide by zero: the full 33-cycle sequence still runs. The result is forced to LO = 0xFFFFFFFF, HI = EX_MX1 as latched, for both signed and unsigned.
- Signed overflow: 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000, HI = 0. This falls out of the absolute-value path and must not be special-cased incorrectly.
- op_EX is ignored while busy; no new operation is accepted and HI/LO are not written. Upstream honours stall, so this occurs only on bench misuse.
- stall = busy & (op_EX != none | hilo_read_EX). MFHI/MFLO and back-to-back HI/LO ops therefore wait for the result.

## Timing
- Reset values: hi_out = 0, lo_out = 0, busy = 0, done = 0, stall = 0, state IDLE, counter 0.
- Reset mid-operation: return to IDLE immediately and clear HI/LO. No done pulse follows.
- Start accepted at edge T (state IDLE, valid mul/div op_EX):
  - busy = 1 from T through edge T+33, i.e. 33 cycles.
  - ITER occupies edges T+1..T+32; FIX commits at edge T+33.
  - hi_out/lo_out carry the new result and done = 1 in the cycle after T+33; busy = 0 in that same cycle.
- Latency from op acceptance to visible result is 33 cycles. A new op may be accepted at edge T+34, while done is high.
- MTHI/MTLO latency is 1 cycle. hi_out/lo_out always reflect committed values; there are no partial results mid-operation.
- stall is combinational from registered busy and the current inputs.

## Test plan
- Reset, then MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; done high exactly one cycle.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIVU 100/7 -> LO=14, HI=2. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 -> after 33 cycles LO=0xFFFFFFFF, HI=0x00001234.
- Start MULT 5*6, then during busy drive hilo_read_EX=1 and a second MULT -> stall=1 each busy cycle, second op ignored, result LO=30, HI=0. MTLO 0xA5A5A5A5 when idle -> LO updates next cycle, HI unchanged.
- Start DIV, assert reset at iteration 10 -> outputs return to reset values immediately, no done pulse; a new MULT 2*3 afterwards completes with LO=6.
